instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction fetch stage directly upstream of the CPU control unit. It holds the program counter and issues in-order word requests to instruction memory. Returned words are buffered in a small prefetch FIFO and presented to the control unit over a valid/ready handshake. It also handles redirects (branch/jump) from the control unit and a halt request.

Parameters:
PC_W, 16, program counter / instruction address width in bits
INSTR_W, 32, instruction word width
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
imem_req_vld  out  1  fetch request valid
imem_req_addr  out  PC_W  fetch byte address
imem_req_rdy  in  1  memory accepts request this cycle
imem_rsp_vld  in  1  response word valid (in order, latency >=1 cycle)
imem_rsp_data  in  INSTR_W  response word
redirect_vld  in  1  control unit redirects fetch
redirect_pc  in  PC_W  new fetch address (word aligned)
halt  in  1  stop issuing new requests while high
instr_vld  out  1  FIFO head valid to control unit
instr  out  INSTR_W  FIFO head instruction
instr_pc  out  PC_W  address of FIFO head
instr_rdy  in  1  control unit consumes head this cycle
busy  out  1  outstanding requests or non-empty FIFO

Behaviour:
- Reset (async, any state): pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0; state=IDLE. Outputs: imem_req_vld=0, imem_req_addr=RESET_PC, instr_vld=0, instr=0, instr_pc=0, busy=0.
- States: IDLE -> RUN unconditionally on first clock after reset. RUN -> HALT when halt=1. HALT -> RUN when halt=0. Any state -> DRAIN on redirect_vld when outstanding>0 (after this cycle's accounting). DRAIN -> RUN when drop_cnt reaches 0, or -> HALT if halt=1 at that point.
- Request issue (RUN only): imem_req_vld=1 iff fifo_count + outstanding < DEPTH; imem_req_addr=pc. On vld&rdy: pc <= pc+4, modulo 2^PC_W wraparound (0xFFFC -> 0x0000 for PC_W=16); outstanding++. Request address is stored in an address FIFO alongside it.
- Request stability: imem_req_addr held stable while vld=1 and rdy=0. Only a redirect may withdraw a pending request.
- Response: on imem_rsp_vld with drop_cnt=0, push {data, matching addr} into FIFO; outstanding--. With drop_cnt>0: discard, drop_cnt--, outstanding--. The credit rule guarantees no FIFO overflow. imem_rsp_vld with outstanding=0 is a protocol error; ignore it and assert (sim only).
- Output: instr_vld = FIFO non-empty; instr/instr_pc = head, combinational from storage. Pop on instr_vld&instr_rdy. Push and pop in the same cycle is allowed, including when full-then-pop and empty-then-push. An empty-then-push entry becomes visible the next cycle (no bypass).
- Redirect (highest priority, any state except IDLE):
  - FIFO flushed the same cycle and instr_vld=0 next cycle.
  - pc <= redirect_pc.
  - drop_cnt <= outstanding after this cycle's request/response accounting. A response arriving in the redirect cycle is dropped and is not counted in drop_cnt.
  - Any request accepted in the redirect cycle is also counted in drop_cnt.
  - A pop in the redirect cycle is still honoured by the control unit side.
- halt: blocks only new requests. Outstanding responses still land in the FIFO, and the FIFO still drains.
- busy = (outstanding!=0) | FIFO non-empty.

Optional Feature:
FETCH_PERF_CNT_EN: adds outputs perf_fetched (32b, count of FIFO pushes), perf_dropped (32b, count of discarded responses) and perf_stall (32b, cycles with imem_req_vld=1 & imem_req_rdy=0). All saturate at 0xFFFFFFFF and reset to 0. Without the macro these ports and counters do not exist; core behaviour is identical.

Test Plan:
- Reset then RUN, memory always ready, 1-cycle latency: req addrs 0x0000,0x0004,0x0008... After fill, instr_vld=1 with instr_pc=0x0000 and instr = word for 0x0000.
- instr_rdy=0 for 20 cycles: exactly DEPTH=4 requests issued, then imem_req_vld=0. FIFO holds pc 0x0000..0x000C. Releasing instr_rdy resumes fetch at 0x0010.
- Memory latency 3 cycles with 2 outstanding; redirect_pc=0x0100 asserted: the 2 stale responses are dropped, FIFO is empty for those cycles, and the first instr_pc after that is 0x0100.
- Redirect in the same cycle as a response and a request accept: both in-flight words dropped (drop_cnt=1 plus that response); next delivered instr_pc = redirect_pc.
- Start at RESET_PC=0xFFF8 (PC_W=16): addresses 0xFFF8, 0xFFFC, 0x0000, 0x0004 in order.
- halt=1 mid-stream with 2 outstanding: no new requests, 2 words delivered, busy falls to 0 once consumed. halt=0 resumes at the next sequential pc.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction-memory bus between the fetch unit and instruction memory.
//   imem_req_vld / imem_req_addr : request issued by the fetch unit
//   imem_req_rdy                 : memory accepts the request this cycle
//   imem_rsp_vld / imem_rsp_data : in-order response word from memory
// Modports: master = fetch unit side, slave = memory side.
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32
);
  logic               imem_req_vld;
  logic [PC_W-1:0]    imem_req_addr;
  logic               imem_req_rdy;
  logic               imem_rsp_vld;
  logic [INSTR_W-1:0] imem_rsp_data;

  modport master (
    output imem_req_vld, imem_req_addr,
    input  imem_req_rdy, imem_rsp_vld, imem_rsp_data
  );

  modport slave (
    input  imem_req_vld, imem_req_addr,
    output imem_req_rdy, imem_rsp_vld, imem_rsp_data
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Instruction fetch stage feeding the CPU control unit. Holds the PC, issues
// in-order word requests to instruction memory, buffers returned words in a
// prefetch FIFO and presents them over a valid/ready handshake. Handles
// redirects (branch/jump) and a halt request.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   imem (master)       : instruction-memory request/response bus
//   redirect_vld/_pc    : control unit redirects fetch to a new address
//   halt                : stop issuing new requests while high
//   instr_vld/instr/
//   instr_pc/instr_rdy  : FIFO head handshake towards the control unit
//   busy                : outstanding requests or non-empty FIFO
//
// Optional feature (macro FETCH_PERF_CNT_EN): saturating 32-bit counters
//   perf_fetched (FIFO pushes), perf_dropped (discarded responses),
//   perf_stall (cycles with a request pending but not accepted).
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  imem,
  input  logic                redirect_vld,
  input  logic [PC_W-1:0]     redirect_pc,
  input  logic                halt,
  output logic                instr_vld,
  output logic [INSTR_W-1:0]  instr,
  output logic [PC_W-1:0]     instr_pc,
  input  logic                instr_rdy,
  output logic                busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_dropped,
  output logic [31:0]         perf_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  // Pointers carry one extra bit so full and empty are distinguishable.
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, HALT, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  // Address queue: one entry per outstanding request, in issue order.
  logic [CW-1:0]   aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
  // Instruction FIFO pointers.
  logic [CW-1:0]   iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;
  // Responses still to be discarded after a redirect.
  logic [CW-1:0]   drop_q, drop_d;

  logic [PC_W-1:0]    addr_mem [DEPTH];
  logic [INSTR_W-1:0] data_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem   [DEPTH];

  logic [CW-1:0] out_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   credit;
  logic          req_acc;
  logic          rsp_ok;
  logic          do_redirect;
  logic          discard;
  logic          push;
  logic          pop;

  assign out_cnt  = aq_wr_q - aq_rd_q;
  assign fifo_cnt = iq_wr_q - iq_rd_q;
  // Requests in flight plus words already buffered must fit the FIFO, so a
  // returning word always has a free slot.
  assign credit   = {1'b0, out_cnt} + {1'b0, fifo_cnt};

  assign imem.imem_req_vld  = (state_q == RUN) && (credit < (CW+1)'(DEPTH));
  assign imem.imem_req_addr = pc_q;

  assign req_acc     = imem.imem_req_vld && imem.imem_req_rdy;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok      = imem.imem_rsp_vld && (out_cnt != '0);
  assign do_redirect = redirect_vld && (state_q != IDLE);
  // Words for the old path are discarded, including one landing in the
  // redirect cycle itself.
  assign discard     = rsp_ok && (do_redirect || (drop_q != '0));
  assign push        = rsp_ok && !discard;

  assign instr_vld = (fifo_cnt != '0);
  assign pop       = instr_vld && instr_rdy;
  assign instr     = instr_vld ? data_mem[iq_rd_q[AW-1:0]] : '0;
  assign instr_pc  = instr_vld ? pc_mem[iq_rd_q[AW-1:0]]   : '0;
  assign busy      = (out_cnt != '0) || instr_vld;

  // NOTE: every signal assigned in this block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    aq_wr_d = aq_wr_q;
    aq_rd_d = aq_rd_q;
    iq_wr_d = iq_wr_q;
    iq_rd_d = iq_rd_q;
    drop_d  = drop_q;

    if (req_acc) begin
      pc_d    = pc_q + PC_W'(4);
      aq_wr_d = aq_wr_q + ONE;
    end
    if (rsp_ok)                    aq_rd_d = aq_rd_q + ONE;
    if (discard && drop_q != '0)   drop_d  = drop_q - ONE;
    if (push)                      iq_wr_d = iq_wr_q + ONE;
    if (pop)                       iq_rd_d = iq_rd_q + ONE;

    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (halt)  state_d = HALT;
      HALT:    if (!halt) state_d = RUN;
      DRAIN:   if (drop_d == '0) state_d = halt ? HALT : RUN;
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything above: flush the FIFO and mark every
    // request still in flight after this cycle's accounting for discard.
    if (do_redirect) begin
      pc_d    = redirect_pc;
      iq_rd_d = iq_wr_q;
      drop_d  = aq_wr_d - aq_rd_d;
      if (drop_d != '0) state_d = DRAIN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      aq_wr_q <= '0;
      aq_rd_q <= '0;
      iq_wr_q <= '0;
      iq_rd_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      aq_wr_q <= aq_wr_d;
      aq_rd_q <= aq_rd_d;
      iq_wr_q <= iq_wr_d;
      iq_rd_q <= iq_rd_d;
      drop_q  <= drop_d;
    end
  end

  // NOTE: storage arrays are not reset; entry validity comes from the reset
  // pointers, and outputs are gated to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (req_acc) addr_mem[aq_wr_q[AW-1:0]] <= pc_q;
    if (push) begin
      data_mem[iq_wr_q[AW-1:0]] <= imem.imem_rsp_data;
      pc_mem[iq_wr_q[AW-1:0]]   <= addr_mem[aq_rd_q[AW-1:0]];
    end
  end

  rsp_without_req_a: assert property (
    @(posedge clk) disable iff (rst) imem.imem_rsp_vld |-> (out_cnt != '0)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;
  logic [31:0] perf_stall_q,   perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_dropped_d = perf_dropped_q;
    perf_stall_d   = perf_stall_q;
    if (push && perf_fetched_q != '1)    perf_fetched_d = perf_fetched_q + 32'd1;
    if (discard && perf_dropped_q != '1) perf_dropped_d = perf_dropped_q + 32'd1;
    if (imem.imem_req_vld && !imem.imem_req_rdy && perf_stall_q != '1)
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit. DUT a (RESET_PC=0) exercises fill,
// back-pressure, redirects and halt against a latency-configurable memory
// model; DUT b (RESET_PC=0xFFF8) exercises PC wraparound. Delivered
// instructions are compared against a queue of expected PCs pushed by the
// stimulus; memory words are a fixed function of their address.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        redirect_vld;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        instr_vld;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_rdy;
  logic        busy;

  logic        b_instr_vld;
  logic [31:0] b_instr;
  logic [15:0] b_instr_pc;
  logic        b_instr_rdy;
  logic        b_busy;

  instr_fetch_unit_if #(.PC_W(16), .INSTR_W(32)) imem_a ();
  instr_fetch_unit_if #(.PC_W(16), .INSTR_W(32)) imem_b ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] a_pf, a_pd, a_ps, b_pf, b_pd, b_ps;
`endif

  instr_fetch_unit #(.PC_W(16), .INSTR_W(32), .DEPTH(4), .RESET_PC(16'h0000)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .imem         (imem_a),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .halt         (halt),
    .instr_vld    (instr_vld),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_rdy    (instr_rdy),
    .busy         (busy)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (a_pf),
    .perf_dropped (a_pd),
    .perf_stall   (a_ps)
`endif
  );

  instr_fetch_unit #(.PC_W(16), .INSTR_W(32), .DEPTH(4), .RESET_PC(16'hFFF8)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .imem         (imem_b),
    .redirect_vld (1'b0),
    .redirect_pc  (16'h0000),
    .halt         (1'b0),
    .instr_vld    (b_instr_vld),
    .instr        (b_instr),
    .instr_pc     (b_instr_pc),
    .instr_rdy    (b_instr_rdy),
    .busy         (b_busy)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (b_pf),
    .perf_dropped (b_pd),
    .perf_stall   (b_ps)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] word(input logic [15:0] a);
    return {~a, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model for DUT a ----------------
  typedef struct {
    int          due;
    logic [15:0] addr;
  } pend_t;

  pend_t       rsp_q[$];
  logic [15:0] acc_log[$];
  logic        mem_rdy;
  int          mem_lat;
  int          mcyc = 0;

  // Acts 1 time unit after each falling edge so settings made by the main
  // sequence at that edge are already visible.
  initial begin
    imem_a.imem_req_rdy  = 1'b0;
    imem_a.imem_rsp_vld  = 1'b0;
    imem_a.imem_rsp_data = '0;
    forever begin
      @(negedge clk);
      #1;
      mcyc++;
      if (rsp_q.size() != 0 && rsp_q[0].due == mcyc) begin
        imem_a.imem_rsp_vld  = 1'b1;
        imem_a.imem_rsp_data = word(rsp_q[0].addr);
        void'(rsp_q.pop_front());
      end else begin
        imem_a.imem_rsp_vld  = 1'b0;
        imem_a.imem_rsp_data = '0;
      end
      imem_a.imem_req_rdy = mem_rdy;
      if (imem_a.imem_req_vld && mem_rdy) begin
        acc_log.push_back(imem_a.imem_req_addr);
        rsp_q.push_back('{due: mcyc + mem_lat, addr: imem_a.imem_req_addr});
      end
    end
  end

  // ---------------- memory model for DUT b (always ready, latency 1) -------
  logic [15:0] b_log[$];
  logic        b_pend = 1'b0;
  logic [15:0] b_pend_addr = '0;

  initial begin
    imem_b.imem_req_rdy  = 1'b1;
    imem_b.imem_rsp_vld  = 1'b0;
    imem_b.imem_rsp_data = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_b.imem_rsp_vld  = b_pend;
      imem_b.imem_rsp_data = b_pend ? word(b_pend_addr) : '0;
      b_pend = imem_b.imem_req_vld;
      if (imem_b.imem_req_vld) begin
        b_pend_addr = imem_b.imem_req_addr;
        b_log.push_back(imem_b.imem_req_addr);
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];

  // Checks the handshake that will complete at the next rising edge, then
  // advances to the next falling edge.
  task automatic cycle();
    logic [15:0] e;
    if (instr_vld && instr_rdy) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_instr: observed pc %0h expected none", instr_pc);
        end
      end else begin
        e = exp_q.pop_front();
        check("instr_pc", {16'h0, instr_pc}, {16'h0, e});
        check("instr", instr, word(e));
      end
    end
    @(negedge clk);
  endtask

  task automatic drain_sb(input int budget);
    int left;
    left = budget;
    instr_rdy = 1'b1;
    while (exp_q.size() != 0 && left > 0) begin
      cycle();
      left--;
    end
    instr_rdy = 1'b0;
    check("sb_drained_in_budget", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    instr_rdy    = 1'b0;
    b_instr_rdy  = 1'b0;
    halt         = 1'b0;
    redirect_vld = 1'b0;
    redirect_pc  = '0;
    mem_rdy      = 1'b1;
    mem_lat      = 1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_req_vld",  imem_a.imem_req_vld, 0);
    check("rst_req_addr", imem_a.imem_req_addr, 32'h0000);
    check("rst_instr_vld", instr_vld, 0);
    check("rst_instr",    instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_busy",     busy, 0);
    check("rst_b_req_addr", imem_b.imem_req_addr, 32'hFFF8);

    // Fill with consumer stalled: exactly DEPTH requests, then stop
    rst = 1'b0;
    repeat (20) cycle();
    check("fill_req_count", acc_log.size(), 4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++)
      check("fill_req_addr", acc_log[i], 32'(i * 4));
    check("fill_req_vld",   imem_a.imem_req_vld, 0);
    check("fill_instr_vld", instr_vld, 1);
    check("fill_head_pc",   instr_pc, 32'h0000);
    check("fill_head_word", instr, word(16'h0000));
    check("fill_busy",      busy, 1);

    // Release consumer: FIFO contents then fetch resumes at 0x0010
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(i * 4));
    drain_sb(60);
    check("resume_addr", (acc_log.size() > 4) ? acc_log[4] : 16'hDEAD, 32'h0010);
    repeat (10) cycle();

    // Redirect with two outstanding requests at latency 3
    mem_lat = 3;
    redirect_vld = 1'b1; redirect_pc = 16'h0040;
    cycle();
    redirect_vld = 1'b0;
    cycle();
    cycle();
    mem_rdy = 1'b0;
    redirect_vld = 1'b1; redirect_pc = 16'h0100;
    check("redir_busy", busy, 1);
    check("redir_last_acc", acc_log[acc_log.size()-1], 32'h0044);
    cycle();
    redirect_vld = 1'b0;
    mem_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("drain_instr_vld", instr_vld, 0);
      check("drain_req_vld", imem_a.imem_req_vld, 0);
      cycle();
    end
    check("post_drain_req_vld",  imem_a.imem_req_vld, 1);
    check("post_drain_req_addr", imem_a.imem_req_addr, 32'h0100);
    check("post_drain_instr_vld", instr_vld, 0);
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0104);
    drain_sb(40);
    repeat (12) cycle();

    // Redirect coinciding with a response and a request accept (latency 1)
    mem_lat = 1;
    redirect_vld = 1'b1; redirect_pc = 16'h0200;
    cycle();
    redirect_vld = 1'b0;
    cycle();
    redirect_vld = 1'b1; redirect_pc = 16'h0300;
    check("coinc_req_vld", imem_a.imem_req_vld, 1);
    cycle();
    redirect_vld = 1'b0;
    check("coinc_instr_vld", instr_vld, 0);
    check("coinc_req_vld_drain", imem_a.imem_req_vld, 0);
    check("coinc_busy", busy, 1);
    cycle();
    check("coinc_last_acc", acc_log[acc_log.size()-1], 32'h0204);
    check("coinc_req_vld_after", imem_a.imem_req_vld, 1);
    check("coinc_req_addr_after", imem_a.imem_req_addr, 32'h0300);
    exp_q.push_back(16'h0300);
    exp_q.push_back(16'h0304);
    drain_sb(40);
    repeat (12) cycle();

    // Halt with two outstanding requests at latency 3
    mem_lat = 3;
    redirect_vld = 1'b1; redirect_pc = 16'h0400;
    cycle();
    redirect_vld = 1'b0;
    cycle();
    halt = 1'b1;
    cycle();
    check("halt_req_vld", imem_a.imem_req_vld, 0);
    check("halt_busy", busy, 1);
    exp_q.push_back(16'h0400);
    exp_q.push_back(16'h0404);
    drain_sb(40);
    check("halt_busy_done", busy, 0);
    check("halt_instr_vld_done", instr_vld, 0);
    repeat (5) cycle();
    check("halt_no_new_req", acc_log[acc_log.size()-1], 32'h0404);
    check("halt_req_vld_hold", imem_a.imem_req_vld, 0);
    halt = 1'b0;
    cycle();
    check("unhalt_req_vld", imem_a.imem_req_vld, 1);
    check("unhalt_req_addr", imem_a.imem_req_addr, 32'h0408);
    exp_q.push_back(16'h0408);
    exp_q.push_back(16'h040C);
    drain_sb(40);

    // PC wraparound on DUT b
    check("wrap_req_count", b_log.size(), 4);
    for (int i = 0; i < 4 && i < b_log.size(); i++)
      check("wrap_req_addr", b_log[i], 32'(16'(16'hFFF8 + 16'(i * 4))));
    check("wrap_head_pc", b_instr_pc, 32'hFFF8);
    check("wrap_head_word", b_instr, word(16'hFFF8));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
